// File: rtl/iic_temp_slave.sv
// iic_temp_slave: I2C responder that emulates an LP75-style temperature sensor.
// The core writes a 16-bit temperature over the register bus. An I2C master
// reads it back as MSB/LSB byte pairs, and can write a config byte.
// Ports:
//   clk, rst       system clock, synchronous active-high reset
//   we_i           register bus write strobe
//   addr_i         register select in addr_i[23:16]
//   data_i         register bus write data
//   data_o         register bus read data (combinational)
//   scl            I2C clock from the master (asynchronous)
//   sda            open-drain I2C data (driven low or released)
module iic_temp_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h48
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  input  logic        scl,
  inout  wire         sda
);

  localparam int unsigned TEMP_W = 16;
  localparam int unsigned CFG_W  = 8;
  localparam int unsigned CNT_W  = 4;

  localparam logic [7:0] REG_TEMP = 8'h01;
  localparam logic [7:0] REG_CFG  = 8'h02;
  localparam logic [7:0] REG_STAT = 8'h03;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_TX, S_TX_ACK, S_RX, S_RX_ACK
  } state_t;

  state_t              state;
  logic [TEMP_W-1:0]   temp;
  logic [CFG_W-1:0]    cfg;
  logic [15:0]         rd_cnt;
  logic                nack_seen;
  logic                addr_hit;
  logic                dir;
  logic                sda_oe;
  logic [CNT_W-1:0]    bit_cnt;
  logic [7:0]          rx_sr;
  logic [TEMP_W-1:0]   tx_sr;
  logic                lsb_byte;
  logic [2:0]          scl_q;
  logic [2:0]          sda_q;

  logic [7:0] reg_sel;
  logic       busy;
  logic       scl_rise, scl_fall, start_det, stop_det, sda_s;
  logic       unused_bits;

  assign sda = sda_oe ? 1'b0 : 1'bz;

  assign reg_sel     = addr_i[23:16];
  assign busy        = (state != S_IDLE);
  assign unused_bits = ^{addr_i[31:24], addr_i[15:0], data_i[31:16]};

  // Two synchronizer stages plus one history stage for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_q <= 3'b111;
      sda_q <= 3'b111;
    end else begin
      scl_q <= {scl_q[1:0], scl};
      sda_q <= {sda_q[1:0], sda};
    end
  end

  assign sda_s     = sda_q[1];
  assign scl_rise  =  scl_q[1] & ~scl_q[2];
  assign scl_fall  = ~scl_q[1] &  scl_q[2];
  assign start_det =  scl_q[1] &  scl_q[2] & ~sda_q[1] &  sda_q[2];
  assign stop_det  =  scl_q[1] &  scl_q[2] &  sda_q[1] & ~sda_q[2];

  // Register bus read mux
  always_comb begin
    data_o = 32'h0;
    case (reg_sel)
      REG_TEMP: data_o = 32'(temp);
      REG_CFG:  data_o = 32'(cfg);
      REG_STAT: data_o = {rd_cnt, 12'h000, nack_seen, busy, addr_hit, dir};
      default:  data_o = 32'h0;
    endcase
  end

  // Protocol FSM, registers and flags; master CFG write is placed after the
  // bus write so it takes priority when both land in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      temp      <= '0;
      cfg       <= '0;
      rd_cnt    <= '0;
      nack_seen <= 1'b0;
      addr_hit  <= 1'b0;
      dir       <= 1'b0;
      sda_oe    <= 1'b0;
      bit_cnt   <= '0;
      rx_sr     <= '0;
      tx_sr     <= '0;
      lsb_byte  <= 1'b0;
    end else begin
      if (we_i) begin
        case (reg_sel)
          REG_TEMP: temp <= data_i[TEMP_W-1:0];
          REG_CFG:  cfg  <= data_i[CFG_W-1:0];
          default: ;
        endcase
      end

      if (start_det) begin
        state     <= S_ADDR;
        bit_cnt   <= '0;
        sda_oe    <= 1'b0;
        addr_hit  <= 1'b0;
        nack_seen <= 1'b0;
      end else if (stop_det) begin
        state  <= S_IDLE;
        sda_oe <= 1'b0;
      end else begin
        case (state)
          S_IDLE: sda_oe <= 1'b0;

          S_ADDR: begin
            if (scl_rise && bit_cnt != CNT_W'(8)) begin
              rx_sr   <= {rx_sr[6:0], sda_s};
              bit_cnt <= bit_cnt + CNT_W'(1);
            end else if (scl_fall && bit_cnt == CNT_W'(8)) begin
              if (rx_sr[7:1] == SLAVE_ADDR) begin
                sda_oe   <= 1'b1;
                addr_hit <= 1'b1;
                dir      <= rx_sr[0];
                state    <= S_ADDR_ACK;
              end else begin
                state <= S_IDLE;
              end
            end
          end

          S_ADDR_ACK: begin
            if (scl_fall) begin
              bit_cnt <= CNT_W'(1);
              if (dir) begin
                // Snapshot TEMP at pair start and drive its MSB immediately
                tx_sr    <= {temp[TEMP_W-2:0], 1'b0};
                sda_oe   <= ~temp[TEMP_W-1];
                rd_cnt   <= rd_cnt + 16'd1;
                lsb_byte <= 1'b0;
                state    <= S_TX;
              end else begin
                sda_oe  <= 1'b0;
                bit_cnt <= '0;
                state   <= S_RX;
              end
            end
          end

          S_TX: begin
            if (scl_fall) begin
              if (bit_cnt == CNT_W'(8)) begin
                sda_oe <= 1'b0;
                state  <= S_TX_ACK;
              end else begin
                sda_oe  <= ~tx_sr[TEMP_W-1];
                tx_sr   <= {tx_sr[TEMP_W-2:0], 1'b0};
                bit_cnt <= bit_cnt + CNT_W'(1);
              end
            end
          end

          // A fall here can only follow a rise that carried an ACK
          S_TX_ACK: begin
            if (scl_rise && sda_s) begin
              nack_seen <= 1'b1;
              sda_oe    <= 1'b0;
              state     <= S_IDLE;
            end else if (scl_fall) begin
              bit_cnt <= CNT_W'(1);
              state   <= S_TX;
              if (!lsb_byte) begin
                sda_oe   <= ~tx_sr[TEMP_W-1];
                tx_sr    <= {tx_sr[TEMP_W-2:0], 1'b0};
                lsb_byte <= 1'b1;
              end else begin
                tx_sr    <= {temp[TEMP_W-2:0], 1'b0};
                sda_oe   <= ~temp[TEMP_W-1];
                rd_cnt   <= rd_cnt + 16'd1;
                lsb_byte <= 1'b0;
              end
            end
          end

          S_RX: begin
            if (scl_rise && bit_cnt != CNT_W'(8)) begin
              rx_sr   <= {rx_sr[6:0], sda_s};
              bit_cnt <= bit_cnt + CNT_W'(1);
              if (bit_cnt == CNT_W'(7)) cfg <= {rx_sr[6:0], sda_s};
            end else if (scl_fall && bit_cnt == CNT_W'(8)) begin
              sda_oe <= 1'b1;
              state  <= S_RX_ACK;
            end
          end

          S_RX_ACK: begin
            if (scl_fall) begin
              sda_oe  <= 1'b0;
              bit_cnt <= '0;
              state   <= S_RX;
            end
          end

          default: begin
            state  <= S_IDLE;
            sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_iic_temp_slave.sv
// tb_iic_temp_slave: directed bench for iic_temp_slave. A behavioural I2C
// master bit-bangs SCL/SDA; register bus tasks poke TEMP/CFG and read STAT.
module tb_iic_temp_slave;

  localparam int Q = 80;  // quarter SCL period; SCL period = 32 clk

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  wire  [31:0] rdata;
  logic        scl = 1'b1;
  logic        m_low = 1'b0;
  wire         sda;

  int n_checks = 0;
  int n_pass   = 0;

  pullup (sda);
  assign sda = m_low ? 1'b0 : 1'bz;

  iic_temp_slave #(.SLAVE_ADDR(7'h48)) dut (
    .clk    (clk),
    .rst    (rst),
    .we_i   (we),
    .addr_i (addr),
    .data_i (wdata),
    .data_o (rdata),
    .scl    (scl),
    .sda    (sda)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic bus_write(input logic [7:0] sel, input logic [31:0] d);
    @(negedge clk);
    we = 1'b1; addr = {8'h00, sel, 16'h0000}; wdata = d;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] sel, output logic [31:0] d);
    @(negedge clk);
    addr = {8'h00, sel, 16'h0000};
    #1 d = rdata;
  endtask

  task automatic i2c_start();
    m_low = 1'b0; #Q;
    scl = 1'b1;   #Q;
    m_low = 1'b1; #Q;
    scl = 1'b0;   #Q;
  endtask

  task automatic i2c_stop();
    m_low = 1'b1; #Q;
    scl = 1'b1;   #Q;
    m_low = 1'b0; #Q;
  endtask

  task automatic write_bit(input logic b);
    m_low = ~b; #Q;
    scl = 1'b1; #(2*Q);
    scl = 1'b0; #Q;
  endtask

  task automatic read_bit(output logic b);
    m_low = 1'b0; #Q;
    scl = 1'b1;   #Q;
    b = sda;      #Q;
    scl = 1'b0;   #Q;
  endtask

  // Returns the slave's acknowledge bit (0 = ACK)
  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(nack);
  endtask

  function automatic logic [31:0] stat(input logic [15:0] cnt, input logic [3:0] flags);
    return {cnt, 12'h000, flags};
  endfunction

  initial begin
    logic [31:0] r;
    logic [7:0]  b;
    logic        ack;
    logic [15:0] exp_rd;
    exp_rd = 16'd0;

    repeat (4) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // Reset state and register map
    check("rst_sda", 32'(sda), 32'h1);
    bus_read(8'h03, r); check("rst_stat", r, 32'h0);
    bus_read(8'h01, r); check("rst_temp", r, 32'h0);
    bus_read(8'h02, r); check("rst_cfg", r, 32'h0);
    bus_write(8'h01, 32'hFFFF_1A80);
    bus_read(8'h01, r); check("temp_rw", r, 32'h0000_1A80);
    bus_write(8'h02, 32'h0000_01A5);
    bus_read(8'h02, r); check("cfg_rw", r, 32'h0000_00A5);
    bus_write(8'h03, 32'hFFFF_FFFF);
    bus_read(8'h03, r); check("stat_ro", r, 32'h0);
    bus_write(8'h07, 32'h1234_5678);
    bus_read(8'h07, r); check("unmapped", r, 32'h0);

    // Two-byte read ending in NACK
    i2c_start();
    write_byte(8'h91, ack); check("rd_addr_ack", 32'(ack), 32'h0);
    read_byte(1'b0, b);     check("rd_msb", 32'(b), 32'h1A);
    read_byte(1'b1, b);     check("rd_lsb", 32'(b), 32'h80);
    exp_rd = 16'd1;
    bus_read(8'h03, r);     check("rd_stat", r, stat(exp_rd, 4'b1011));
    i2c_stop();

    // Master write of the config byte
    i2c_start();
    write_byte(8'h90, ack); check("wr_addr_ack", 32'(ack), 32'h0);
    write_byte(8'h5C, ack); check("wr_data_ack", 32'(ack), 32'h0);
    i2c_stop();
    bus_read(8'h02, r);     check("wr_cfg", r, 32'h5C);
    bus_read(8'h03, r);     check("wr_stat", r, stat(exp_rd, 4'b0010));

    // Foreign address is ignored
    i2c_start();
    write_byte(8'h94, ack); check("miss_nack", 32'(ack), 32'h1);
    bus_read(8'h03, r);     check("miss_stat", r, stat(exp_rd, 4'b0000));
    write_byte(8'h33, ack); check("miss_data_nack", 32'(ack), 32'h1);
    i2c_stop();
    bus_read(8'h02, r);     check("miss_cfg", r, 32'h5C);

    // Four-byte read; TEMP update mid-pair must not tear the pair
    i2c_start();
    write_byte(8'h91, ack); check("rd4_addr_ack", 32'(ack), 32'h0);
    read_byte(1'b0, b);     check("rd4_b0", 32'(b), 32'h1A);
    bus_write(8'h01, 32'h0000_0123);
    read_byte(1'b0, b);     check("rd4_b1", 32'(b), 32'h80);
    read_byte(1'b0, b);     check("rd4_b2", 32'(b), 32'h01);
    read_byte(1'b1, b);     check("rd4_b3", 32'(b), 32'h23);
    exp_rd = exp_rd + 16'd2;
    bus_read(8'h03, r);     check("rd4_stat", r, stat(exp_rd, 4'b1011));
    i2c_stop();

    // Write, repeated START, read
    i2c_start();
    write_byte(8'h90, ack); check("rs_waddr_ack", 32'(ack), 32'h0);
    write_byte(8'h11, ack); check("rs_wdata_ack", 32'(ack), 32'h0);
    bus_read(8'h03, r);     check("rs_busy_stat", r, stat(exp_rd, 4'b0110));
    i2c_start();
    write_byte(8'h91, ack); check("rs_raddr_ack", 32'(ack), 32'h0);
    read_byte(1'b0, b);     check("rs_msb", 32'(b), 32'h01);
    read_byte(1'b1, b);     check("rs_lsb", 32'(b), 32'h23);
    i2c_stop();
    exp_rd = exp_rd + 16'd1;
    bus_read(8'h02, r);     check("rs_cfg", r, 32'h11);
    bus_read(8'h03, r);     check("rs_stat", r, stat(exp_rd, 4'b1011));

    // Reset while the slave holds SDA low (TEMP bit 15 is 0)
    i2c_start();
    write_byte(8'h91, ack); check("rt_addr_ack", 32'(ack), 32'h0);
    repeat (2) @(negedge clk);
    check("rt_sda_low", 32'(sda), 32'h0);
    rst = 1'b1;
    @(posedge clk);
    #1 check("rt_sda_rel", 32'(sda), 32'h1);
    @(negedge clk) rst = 1'b0;
    bus_read(8'h03, r);     check("rt_stat", r, 32'h0);
    bus_read(8'h01, r);     check("rt_temp", r, 32'h0);
    i2c_stop();
    bus_write(8'h01, 32'h0000_1A80);
    i2c_start();
    write_byte(8'h91, ack); check("rt2_addr_ack", 32'(ack), 32'h0);
    read_byte(1'b0, b);     check("rt2_msb", 32'(b), 32'h1A);
    read_byte(1'b1, b);     check("rt2_lsb", 32'(b), 32'h80);
    i2c_stop();
    bus_read(8'h03, r);     check("rt2_stat", r, stat(16'd1, 4'b1011));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
